jt49_wrq: RTL and testbench
===========================

// Module: jt49_wrq
// PURPOSE
//  Register-write scheduler between a host bus and the JT49 PSG core. Queues host register
//  writes in a small FIFO and issues them to the core one at a time, only on base clock-enable
//  (cen) cycles, with a programmable minimum spacing of cen pulses between writes.
//  Sits beside the clock-enable divider and feeds the core's register-file write port.
// PARAMETERS
//  DEPTH    4  FIFO entries; power of two, 2..16
//  MIN_GAP  1  cen pulses that must elapse after an issued write before the next one; 0..15
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  cen        in   1  base clock enable; same signal the PSG core's divider consumes
//  wr_valid   in   1  host write request
//  wr_ready   out  1  host write accepted when wr_valid & wr_ready at posedge clk
//  wr_addr    in   4  PSG register index 0..15
//  wr_data    in   8  register value
//  flush      in   1  synchronous: drop all queued entries, abort gap
//  psg_wr     out  1  one-clk write strobe to core; only ever high while cen is high
//  psg_addr   out  4  register index, valid while psg_wr
//  psg_din    out  8  register value, valid while psg_wr
//  busy       out  1  FIFO not empty or gap counting
//  level      out  $clog2(DEPTH)+1  entries currently queued
//  ovf        out  1  sticky: wr_valid seen while wr_ready low; cleared by rst or flush
//  rd_addr    in   4  shadow read index       (JT49_WRQ_SHADOW_EN only)
//  rd_data    out  8  shadow read value       (JT49_WRQ_SHADOW_EN only)
// BEHAVIOUR
//  Reset: FIFO empty, level=0, state IDLE, gap counter 0, psg_wr=0, psg_addr=0, psg_din=0,
//   busy=0, ovf=0, wr_ready=1, shadow regs all 0. Reset mid-issue discards everything.
//  FIFO: entries {addr,data}; wr_ready = !full (no same-cycle bypass when full, even if popping).
//   Push at edge N makes the entry eligible from cycle N+1. Pointers wrap modulo DEPTH.
//  FSM states IDLE, ISSUE, GAP (registered state; psg_* outputs decoded from state + head):
//   IDLE : FIFO non-empty -> ISSUE.
//   ISSUE: psg_wr = cen; psg_addr/psg_din = FIFO head. On edge with cen=1: pop;
//          MIN_GAP=0 -> stay ISSUE if another entry remains (after pop) else IDLE;
//          MIN_GAP>0 -> GAP with gap counter = MIN_GAP. cen=0: hold, outputs stay stable.
//   GAP  : psg_wr=0; counter decrements on each cen edge; reaching 0 -> ISSUE if non-empty,
//          else IDLE. A write arriving during GAP waits.
//  psg_addr/psg_din hold last issued values outside ISSUE (0 after reset).
//  Simultaneous push and pop: both take effect; level unchanged.
//  flush: highest priority over push/pop that cycle; FIFO emptied, ->IDLE, counter 0, ovf=0,
//   psg_wr forced 0 that cycle; a wr_valid in the flush cycle is dropped (not counted as ovf).
//  Issue order strictly FIFO; duplicate addresses are not coalesced (reg 13 rewrites matter).
// CONFIGURATION
//  JT49_WRQ_SHADOW_EN defined: 16x8 shadow register file updated on each issued psg_wr
//   (not on push); rd_data = shadow[rd_addr] combinationally; reflects core-visible state.
//  Undefined: rd_addr/rd_data ports absent; no shadow storage.
// STRUCTURE
//  Package jt49_pkg: JT49_NREGS=16, JT49_AW=4, JT49_DW=8, wrq_state_t enum {IDLE,ISSUE,GAP},
//   REG_ENV_SHAPE=4'd13 constant.
//  Sub-module jt49_wrq_fifo: parameterised sync FIFO (push/pop/full/empty/level/flush).
//  Top holds FSM, gap counter, ovf flag, optional shadow file.
// TESTING
//  1 Reset, cen every 4th clk, push (3,0x55): psg_wr high on first cen cycle after push,
//    psg_addr=3, psg_din=0x55, exactly one clk; level 1->0; busy falls after pop (MIN_GAP=0).
//  2 MIN_GAP=2, push 3 writes back-to-back: psg_wr pulses separated by exactly 3 cen pulses;
//    order preserved; wr_ready stays 1.
//  3 DEPTH=4, cen held 0, push 5 writes: 5th sees wr_ready=0, ovf=1, level=4; enable cen ->
//    first four issued in order, 5th never appears.
//  4 Full FIFO, cen=1, push and pop same cycle: push refused (wr_ready=0), level 4->3.
//  5 flush during GAP with 2 queued: next cycle level=0, busy=0, ovf=0, no psg_wr thereafter;
//    rst asserted mid-ISSUE with cen=1 -> psg_wr=0 immediately (async).
//  6 JT49_WRQ_SHADOW_EN: push (13,0x0E), rd_addr=13 -> rd_data=0 until the issue cycle,
//    0x0E from the following cycle; other addresses remain 0.

Source files
------------

// File: rtl/jt49_pkg.sv
// ----------------------------------------------------------------------------
// jt49_pkg
// Shared types and constants for the JT49 register-write queue.
//   JT49_NREGS     number of PSG registers (16)
//   JT49_AW/DW     register index / value widths
//   REG_ENV_SHAPE  envelope-shape register; every write to it retriggers the
//                  envelope, which is why queued writes are never coalesced
//   wrq_state_t    scheduler states
//   wrq_entry_t    one queued write {addr, data}
// ----------------------------------------------------------------------------
package jt49_pkg;
    localparam int JT49_NREGS = 16;
    localparam int JT49_AW    = 4;
    localparam int JT49_DW    = 8;

    localparam logic [JT49_AW-1:0] REG_ENV_SHAPE = 4'd13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } wrq_state_t;

    typedef struct packed {
        logic [JT49_AW-1:0] addr;
        logic [JT49_DW-1:0] data;
    } wrq_entry_t;
endpackage

// File: rtl/jt49_wrq_fifo.sv
// ----------------------------------------------------------------------------
// jt49_wrq_fifo
// Synchronous FIFO of register writes. A push while full and a pop while
// empty are ignored; flush empties the FIFO and overrides push/pop.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous clear
//   push, din       enqueue request and entry
//   pop             dequeue request (head advances at the edge)
//   dout            current head entry (meaningful while !empty)
//   full, empty     status
//   level           entries currently stored, 0..DEPTH
// ----------------------------------------------------------------------------
module jt49_wrq_fifo
    import jt49_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  wrq_entry_t    din,
    input  logic          pop,
    output wrq_entry_t    dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    wrq_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          do_push, do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + LW'(1);
            else if (!do_push && do_pop) count <= count - LW'(1);
        end
    end

    // NOTE: storage has no reset; stale contents are unreachable because the
    // count and pointers are reset, and this keeps the array in plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/jt49_wrq.sv
// ----------------------------------------------------------------------------
// jt49_wrq
// Register-write scheduler between the host bus and the JT49 PSG core. Host
// writes are queued and issued one at a time on cen cycles, with MIN_GAP cen
// pulses of spacing after each issued write.
// Optional feature macro: JT49_WRQ_SHADOW_EN adds a 16x8 shadow copy of the
// core-visible registers with a combinational read port (rd_addr/rd_data).
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cen                    base clock enable shared with the PSG divider
//   wr_valid/wr_ready      host handshake; wr_addr/wr_data the write
//   flush                  drop queue, abort spacing, clear ovf
//   psg_wr/psg_addr/psg_din  write strobe and payload to the core
//   busy                   queue non-empty or spacing in progress
//   level                  queued entries
//   ovf                    sticky: write offered while not ready
//   rd_addr/rd_data        shadow read port (shadow build only)
// ----------------------------------------------------------------------------
module jt49_wrq
    import jt49_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MIN_GAP = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [JT49_AW-1:0]     wr_addr,
    input  logic [JT49_DW-1:0]     wr_data,
    input  logic                   flush,
    output logic                   psg_wr,
    output logic [JT49_AW-1:0]     psg_addr,
    output logic [JT49_DW-1:0]     psg_din,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf
`ifdef JT49_WRQ_SHADOW_EN
    ,
    input  logic [JT49_AW-1:0]     rd_addr,
    output logic [JT49_DW-1:0]     rd_data
`endif
);
    localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP);

    wrq_state_t         state, state_nxt;
    logic [3:0]         gap_cnt, gap_nxt;
    wrq_entry_t         head;
    logic               fifo_full, fifo_empty;
    logic [JT49_AW-1:0] last_addr;
    logic [JT49_DW-1:0] last_data;

    jt49_wrq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (wr_valid),
        .din   ('{addr: wr_addr, data: wr_data}),
        .pop   (psg_wr),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // The strobe, and hence the pop, only happens on a cen cycle in ISSUE.
    assign psg_wr   = (state == ISSUE) && cen && !flush;
    assign psg_addr = (state == ISSUE) ? head.addr : last_addr;
    assign psg_din  = (state == ISSUE) ? head.data : last_data;
    assign wr_ready = !fifo_full;
    assign busy     = !fifo_empty || (state == GAP);

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        if (flush) begin
            state_nxt = IDLE;
            gap_nxt   = '0;
        end else begin
            case (state)
                IDLE: if (!fifo_empty) state_nxt = ISSUE;
                ISSUE: if (cen) begin
                    if (MIN_GAP == 0) begin
                        // Decide on the pre-edge level: a push landing this
                        // edge is only eligible from the next cycle.
                        state_nxt = (level > 1) ? ISSUE : IDLE;
                    end else begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_LOAD;
                    end
                end
                GAP: if (cen) begin
                    gap_nxt = gap_cnt - 4'd1;
                    if (gap_cnt <= 4'd1) state_nxt = fifo_empty ? IDLE : ISSUE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            ovf       <= 1'b0;
            last_addr <= '0;
            last_data <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            if (flush)                     ovf <= 1'b0;
            else if (wr_valid && !wr_ready) ovf <= 1'b1;
            if (psg_wr) begin
                last_addr <= head.addr;
                last_data <= head.data;
            end
        end
    end

`ifdef JT49_WRQ_SHADOW_EN
    // Mirrors what the core has actually been written, so it updates on the
    // issued strobe rather than on host push. Cleared on reset like the core.
    logic [JT49_DW-1:0] shadow [JT49_NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < JT49_NREGS; i++) shadow[i] <= '0;
        end else if (psg_wr) begin
            shadow[head.addr] <= head.data;
        end
    end

    assign rd_data = shadow[rd_addr];
`endif
endmodule

// File: tb/tb_jt49_wrq.sv
// ----------------------------------------------------------------------------
// tb_jt49_wrq
// Two queues (MIN_GAP=0 and MIN_GAP=2, DEPTH=4) driven by identical stimulus
// and compared against a queue-based reference of the scheduling rules.
// ----------------------------------------------------------------------------
module tb_jt49_wrq;
    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst, cen, wr_valid, flush;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data;

    logic       o_ready [2];
    logic       o_wr    [2];
    logic [3:0] o_addr  [2];
    logic [7:0] o_din   [2];
    logic       o_busy  [2];
    logic [2:0] o_level [2];
    logic       o_ovf   [2];
    logic [7:0] o_rd    [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jt49_wrq #(.DEPTH(4), .MIN_GAP(0)) u0 (
        .clk(clk), .rst(rst), .cen(cen), .wr_valid(wr_valid), .wr_ready(o_ready[0]),
        .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .psg_wr(o_wr[0]),
        .psg_addr(o_addr[0]), .psg_din(o_din[0]), .busy(o_busy[0]),
        .level(o_level[0]), .ovf(o_ovf[0])
`ifdef JT49_WRQ_SHADOW_EN
        , .rd_addr(rd_addr), .rd_data(o_rd[0])
`endif
    );

    jt49_wrq #(.DEPTH(4), .MIN_GAP(2)) u1 (
        .clk(clk), .rst(rst), .cen(cen), .wr_valid(wr_valid), .wr_ready(o_ready[1]),
        .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .psg_wr(o_wr[1]),
        .psg_addr(o_addr[1]), .psg_din(o_din[1]), .busy(o_busy[1]),
        .level(o_level[1]), .ovf(o_ovf[1])
`ifdef JT49_WRQ_SHADOW_EN
        , .rd_addr(rd_addr), .rd_data(o_rd[1])
`endif
    );

`ifndef JT49_WRQ_SHADOW_EN
    assign o_rd[0] = 8'h00;
    assign o_rd[1] = 8'h00;
`endif

    // ---------------- reference model ----------------
    // Per queue: pending writes, whether the head is being presented to the
    // core, and how many cen pulses of spacing are still owed.
    ent_t       mq [2][8];
    int         msz [2];
    bit         armed [2];
    int         gap [2];
    bit         movf [2];
    logic [3:0] last_a [2];
    logic [7:0] last_d [2];

    bit         e_wr [2];
    logic [3:0] e_addr [2];
    logic [7:0] e_din [2];
    int         e_level [2];
    bit         e_busy [2];
    bit         e_ready [2];
    bit         e_ovf [2];

    function automatic int gapv(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            msz[i] = 0; armed[i] = 0; gap[i] = 0; movf[i] = 0;
            last_a[i] = '0; last_d[i] = '0;
        end
    endtask

    task automatic calc_exp();
        for (int i = 0; i < 2; i++) begin
            e_wr[i]    = armed[i] && cen && !flush;
            e_addr[i]  = armed[i] ? mq[i][0].a : last_a[i];
            e_din[i]   = armed[i] ? mq[i][0].d : last_d[i];
            e_level[i] = msz[i];
            e_busy[i]  = (msz[i] > 0) || (gap[i] > 0);
            e_ready[i] = msz[i] < 4;
            e_ovf[i]   = movf[i];
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int n;
            bit iss, pok;
            n = msz[i];
            if (flush) begin
                msz[i] = 0; armed[i] = 0; gap[i] = 0; movf[i] = 0;
            end else begin
                iss = armed[i] && cen;
                pok = wr_valid && (n < 4);
                if (wr_valid && !pok) movf[i] = 1;
                if (armed[i]) begin
                    if (cen) begin
                        if (gapv(i) == 0) armed[i] = (n > 1);
                        else begin armed[i] = 0; gap[i] = gapv(i); end
                    end
                end else if (gap[i] > 0) begin
                    if (cen) begin
                        gap[i]--;
                        if (gap[i] == 0) armed[i] = (n > 0);
                    end
                end else begin
                    armed[i] = (n > 0);
                end
                if (iss) begin
                    last_a[i] = mq[i][0].a;
                    last_d[i] = mq[i][0].d;
                    for (int j = 0; j < 7; j++) mq[i][j] = mq[i][j+1];
                    msz[i]--;
                end
                if (pok) begin
                    mq[i][msz[i]] = '{a: wr_addr, d: wr_data};
                    msz[i]++;
                end
            end
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic apply(input bit c, input bit v, input logic [3:0] a,
                         input logic [7:0] d, input bit f);
        cen = c; wr_valid = v; wr_addr = a; wr_data = d; flush = f;
        #1;
        calc_exp();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((o_busy[0] || o_busy[1]) && k < 60) begin
            apply(1, 0, 4'h0, 8'h00, 0);
            advance();
            k++;
        end
        n_vec++;
        if (o_busy[0] || o_busy[1]) begin
            n_err++;
            $display("FAIL drain_timeout busy=%b/%b want 0/0", o_busy[0], o_busy[1]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; cen = 0; wr_valid = 0; flush = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({o_wr[i], o_addr[i], o_din[i], o_busy[i], o_level[i], o_ovf[i], o_ready[i]}
                !== {1'b0, 4'h0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL reset_state dut%0d wr=%b addr=%h din=%h busy=%b lvl=%0d ovf=%b rdy=%b",
                         i, o_wr[i], o_addr[i], o_din[i], o_busy[i], o_level[i], o_ovf[i], o_ready[i]);
            end
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            apply((k % 4) == 3, k == 0, 4'd3, 8'h55, 0);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (o_wr[i] !== e_wr[i]) begin
                    n_err++;
                    $display("FAIL single_wr dut%0d cyc%0d got %b want %b", i, k, o_wr[i], e_wr[i]);
                end
            end
            if (o_wr[0]) begin
                pulses++;
                n_vec++;
                if (k != 3 || o_addr[0] !== 4'd3 || o_din[0] !== 8'h55) begin
                    n_err++;
                    $display("FAIL single_issue cyc%0d addr=%h din=%h want cyc3 addr=3 din=55",
                             k, o_addr[0], o_din[0]);
                end
            end
            advance();
        end
        n_vec++;
        if (pulses != 1 || o_level[0] !== 3'd0 || o_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL single_after pulses=%0d level=%0d busy=%b want 1/0/0",
                     pulses, o_level[0], o_busy[0]);
        end
    endtask

    task automatic test_gap();
        logic [3:0] got [3];
        int pulses, cens, k;
        pulses = 0; cens = 0; k = 0;
        while (pulses < 3 && k < 80) begin
            apply(1'($urandom_range(0, 1)), k < 3, 4'(7 + k), 8'($urandom), 0);
            if (k < 3) begin
                n_vec++;
                if (o_ready[1] !== 1'b1) begin
                    n_err++;
                    $display("FAIL gap_ready cyc%0d got %b want 1", k, o_ready[1]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (o_wr[i] !== e_wr[i] || o_addr[i] !== e_addr[i]) begin
                    n_err++;
                    $display("FAIL gap_model dut%0d wr=%b addr=%h want %b %h",
                             i, o_wr[i], o_addr[i], e_wr[i], e_addr[i]);
                end
            end
            if (cen) cens++;
            if (o_wr[1]) begin
                if (pulses > 0) begin
                    n_vec++;
                    if (cens != 3) begin
                        n_err++;
                        $display("FAIL gap_spacing got %0d cen pulses want 3", cens);
                    end
                end
                got[pulses] = o_addr[1];
                pulses++;
                cens = 0;
            end
            advance();
            k++;
        end
        n_vec++;
        if (pulses != 3 || got[0] !== 4'd7 || got[1] !== 4'd8 || got[2] !== 4'd9) begin
            n_err++;
            $display("FAIL gap_order pulses=%0d order=%h,%h,%h want 3 7,8,9",
                     pulses, got[0], got[1], got[2]);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [3:0] got [8];
        int n;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            apply(0, 1, 4'(k + 1), 8'($urandom), 0);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (o_ready[i] !== (k < 4) || (k == 4 && o_level[i] !== 3'd4)) begin
                    n_err++;
                    $display("FAIL ovf_fill dut%0d push%0d ready=%b level=%0d", i, k, o_ready[i], o_level[i]);
                end
            end
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_ovf[i] !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_flag dut%0d got %b want 1", i, o_ovf[i]);
            end
        end
        for (int k = 0; k < 20; k++) begin
            apply(1, 0, 4'h0, 8'h00, 0);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (o_wr[i] !== e_wr[i] || o_din[i] !== e_din[i]) begin
                    n_err++;
                    $display("FAIL ovf_drain dut%0d wr=%b din=%h want %b %h",
                             i, o_wr[i], o_din[i], e_wr[i], e_din[i]);
                end
            end
            if (o_wr[0] && n < 8) begin got[n] = o_addr[0]; n++; end
            advance();
        end
        n_vec++;
        if (n != 4 || got[0] !== 4'd1 || got[1] !== 4'd2 || got[2] !== 4'd3 || got[3] !== 4'd4) begin
            n_err++;
            $display("FAIL ovf_order issued=%0d first=%h,%h,%h,%h want 4 1,2,3,4",
                     n, got[0], got[1], got[2], got[3]);
        end
    endtask

    task automatic test_full_pushpop();
        drain();
        for (int k = 0; k < 5; k++) begin
            apply(0, k < 4, 4'(k), 8'(k * 17), 0);
            advance();
        end
        apply(1, 1, 4'hF, 8'hFF, 0);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_ready[i] !== 1'b0 || o_wr[i] !== 1'b1 || o_level[i] !== 3'd4) begin
                n_err++;
                $display("FAIL full_pp_pre dut%0d ready=%b wr=%b level=%0d want 0 1 4",
                         i, o_ready[i], o_wr[i], o_level[i]);
            end
        end
        advance();
        apply(0, 0, 4'h0, 8'h00, 0);
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_level[i] !== 3'd3) begin
                n_err++;
                $display("FAIL full_pp_level dut%0d got %0d want 3", i, o_level[i]);
            end
        end
        drain();
    endtask

    task automatic test_flush_reset();
        for (int k = 0; k < 4; k++) begin
            apply(0, k < 3, 4'(k + 10), 8'($urandom), 0);
            advance();
        end
        apply(1, 0, 4'h0, 8'h00, 0);
        advance();
        apply(1, 1, 4'h2, 8'h22, 1);
        n_vec++;
        if (o_level[1] !== 3'd2 || o_busy[1] !== 1'b1 || o_wr[0] !== 1'b0 || o_wr[1] !== 1'b0) begin
            n_err++;
            $display("FAIL flush_pre level=%0d busy=%b wr=%b/%b want 2 1 0/0",
                     o_level[1], o_busy[1], o_wr[0], o_wr[1]);
        end
        advance();
        for (int k = 0; k < 8; k++) begin
            apply(1, 0, 4'h0, 8'h00, 0);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (o_wr[i] !== 1'b0 || o_level[i] !== 3'd0 || o_busy[i] !== 1'b0 || o_ovf[i] !== 1'b0) begin
                    n_err++;
                    $display("FAIL flush_post dut%0d wr=%b level=%0d busy=%b ovf=%b want 0 0 0 0",
                             i, o_wr[i], o_level[i], o_busy[i], o_ovf[i]);
                end
            end
            advance();
        end
        // Reset while the head is being presented with cen high.
        apply(0, 1, 4'h5, 8'hA5, 0); advance();
        apply(0, 0, 4'h0, 8'h00, 0); advance();
        apply(1, 0, 4'h0, 8'h00, 0);
        n_vec++;
        if (o_wr[0] !== e_wr[0] || o_addr[0] !== 4'h5) begin
            n_err++;
            $display("FAIL rst_pre wr=%b addr=%h want %b 5", o_wr[0], o_addr[0], e_wr[0]);
        end
        rst = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (o_wr[i] !== 1'b0 || o_addr[i] !== 4'h0 || o_level[i] !== 3'd0) begin
                n_err++;
                $display("FAIL rst_async dut%0d wr=%b addr=%h level=%0d want 0 0 0",
                         i, o_wr[i], o_addr[i], o_level[i]);
            end
        end
        @(negedge clk);
        model_reset();
        rst = 0;
    endtask

`ifdef JT49_WRQ_SHADOW_EN
    task automatic test_shadow();
        logic [7:0] want;
        rd_addr = 4'd13;
        for (int k = 0; k < 4; k++) begin
            apply(k == 2, k == 0, 4'd13, 8'h0E, 0);
            want = (k == 3) ? 8'h0E : 8'h00;
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (o_rd[i] !== want || (k == 2 && o_wr[i] !== 1'b1)) begin
                    n_err++;
                    $display("FAIL shadow_r13 dut%0d cyc%0d rd=%h wr=%b want %h", i, k, o_rd[i], o_wr[i], want);
                end
            end
            advance();
        end
        for (int a = 0; a < 16; a++) begin
            if (a == 13) continue;
            rd_addr = 4'(a);
            #1;
            n_vec++;
            if (o_rd[0] !== 8'h00 || o_rd[1] !== 8'h00) begin
                n_err++;
                $display("FAIL shadow_other addr%0d rd=%h/%h want 00", a, o_rd[0], o_rd[1]);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            apply($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  4'($urandom), 8'($urandom), $urandom_range(0, 39) == 0);
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if (o_wr[i] !== e_wr[i] || o_addr[i] !== e_addr[i] || o_din[i] !== e_din[i]) begin
                    n_err++;
                    $display("FAIL rand_psg dut%0d cyc%0d wr=%b addr=%h din=%h want %b %h %h",
                             i, k, o_wr[i], o_addr[i], o_din[i], e_wr[i], e_addr[i], e_din[i]);
                end
                n_vec++;
                if (o_level[i] !== 3'(e_level[i]) || o_busy[i] !== e_busy[i] ||
                    o_ready[i] !== e_ready[i] || o_ovf[i] !== e_ovf[i]) begin
                    n_err++;
                    $display("FAIL rand_status dut%0d cyc%0d level=%0d busy=%b rdy=%b ovf=%b want %0d %b %b %b",
                             i, k, o_level[i], o_busy[i], o_ready[i], o_ovf[i],
                             e_level[i], e_busy[i], e_ready[i], e_ovf[i]);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_overflow();
        test_full_pushpop();
        test_flush_reset();
`ifdef JT49_WRQ_SHADOW_EN
        test_shadow();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
